// File: rtl/krnl_partialknn_uram_1r1w_pipe_if.sv
// Write/read port bundle for the kernel-local 1R1W buffer.
// master = client side, slave = buffer side.
interface krnl_partialknn_uram_1r1w_pipe_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 11
);
  logic                      wr_en;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [DATA_WIDTH/8-1:0]   wr_be;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic                      rd_en;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      rd_valid;

  modport master (
    output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/krnl_partialknn_uram_1r1w_pipe.sv
// Simple-dual-port kernel buffer: byte-enabled write, pipelined write-first read,
// and a hardware clear engine that zeroes the array after reset or on request.
module krnl_partialknn_uram_1r1w_pipe #(
  parameter int DATA_WIDTH     = 256,
  parameter int ADDR_WIDTH     = 11,
  parameter int DEPTH          = 2048,
  parameter int READ_LATENCY   = 3,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_req,
  output logic init_busy,
  krnl_partialknn_uram_1r1w_pipe_if.slave bus
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    idle;
  logic                    wr_in_range;
  logic                    rd_in_range;
  logic                    wr_ok;
  logic                    rd_ok;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_vld;

  assign idle        = (state == IDLE);
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_W);
  assign wr_ok       = idle & bus.wr_en & wr_in_range;
  assign rd_ok       = idle & bus.rd_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      init_busy <= (CLEAR_ON_RESET != 0);
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            state     <= CLEAR;
            init_busy <= 1'b1;
            cnt       <= '0;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            cnt       <= '0;
            state     <= IDLE;
            init_busy <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state     <= IDLE;
          init_busy <= 1'b0;
        end
      endcase
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (bus.wr_be[i]) mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
  end

  // Word captured at issue: prior contents merged with a same-edge write.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem[bus.rd_addr];
    if (wr_ok && (bus.wr_addr == bus.rd_addr)) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (bus.wr_be[i]) rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld <= '0;
      for (int unsigned k = 0; k < READ_LATENCY; k++) pipe_data[k] <= '0;
    end else begin
      pipe_vld[0] <= rd_ok;
      if (rd_ok) pipe_data[0] <= rd_word;
      for (int unsigned k = 1; k < READ_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        if (pipe_vld[k-1]) pipe_data[k] <= pipe_data[k-1];
      end
    end
  end

  assign bus.rd_data  = pipe_data[READ_LATENCY-1];
  assign bus.rd_valid = pipe_vld[READ_LATENCY-1];

endmodule
